// File: rtl/dispatcher_pkg.sv
// Shared types and helpers for the matrix block dispatcher.
package dispatcher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        WAIT_ACK,
        DRAIN,
        DONE
    } state_t;

    localparam int MAX_PU = 32;

    function automatic int unsigned popcount(input logic [MAX_PU-1:0] v);
        int unsigned n;
        n = 0;
        for (int b = 0; b < MAX_PU; b++) begin
            n = n + {31'd0, v[b]};
        end
        return n;
    endfunction

endpackage

// File: rtl/block_dispatcher_rr_picker.sv
// Round-robin picker: first idle processor strictly after ptr, cyclically.
module rr_picker #(
    parameter int NUM_PU = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NUM_PU-1:0] idle,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [PTR_W-1:0]  idx
);

    int pos;

    // Scan farthest-first so the nearest idle slot after ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        pos   = 0;
        for (int k = NUM_PU; k >= 1; k--) begin
            pos = (int'(ptr) + k) % NUM_PU;
            if (idle[pos]) begin
                found = 1'b1;
                idx   = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Walks the mu x mu C-block grid and hands (row, col) pairs to idle processors.
// Optional run-length counter enabled by DISPATCH_PERF_COUNTER_EN.
module block_dispatcher
    import dispatcher_pkg::*;
#(
    parameter int NUM_PU      = 2,
    parameter int INDEX_WIDTH = 4,
    parameter int CNT_WIDTH   = 2 * INDEX_WIDTH
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic                          in_start,
    input  logic [INDEX_WIDTH-1:0]        in_mu,
    input  logic [NUM_PU-1:0]             in_index_ack,
    input  logic [NUM_PU-1:0]             in_result_ready,
    output logic [NUM_PU-1:0]             out_index_ready,
    output logic [NUM_PU*INDEX_WIDTH-1:0] out_row_index,
    output logic [NUM_PU*INDEX_WIDTH-1:0] out_col_index,
    output logic                          out_busy,
    output logic                          out_done,
    output logic [31:0]                   out_cycle_count
);

    localparam int PTR_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [INDEX_WIDTH-1:0] mu_q;
    logic [INDEX_WIDTH-1:0] i_q;
    logic [INDEX_WIDTH-1:0] j_q;
    logic [CNT_WIDTH-1:0]   issued_q;
    logic [CNT_WIDTH-1:0]   completed_q;
    logic [CNT_WIDTH-1:0]   completed_nxt;
    logic [CNT_WIDTH-1:0]   total;
    logic [NUM_PU-1:0]      busy_q;
    logic [NUM_PU-1:0]      accepted;
    logic [PTR_W-1:0]       ptr_q;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_found;
    logic                   tracking;
    logic                   start_fire;
    logic                   dispatch_fire;
    logic                   ack_fire;

    rr_picker #(
        .NUM_PU (NUM_PU),
        .PTR_W  (PTR_W)
    ) u_picker (
        .idle  (~busy_q),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        total         = CNT_WIDTH'(mu_q) * CNT_WIDTH'(mu_q);
        tracking      = (state == DISPATCH) || (state == WAIT_ACK)
                     || (state == DRAIN);
        accepted      = tracking ? (in_result_ready & busy_q) : '0;
        completed_nxt = completed_q
                      + CNT_WIDTH'(popcount(MAX_PU'(accepted)));
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        start_fire    = 1'b0;
        dispatch_fire = 1'b0;
        ack_fire      = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_start) begin
                    start_fire = 1'b1;
                    state_nxt  = (in_mu == '0) ? DONE : DISPATCH;
                end
            end
            DISPATCH: begin
                if (issued_q == total) begin
                    state_nxt = DRAIN;
                end else if (pick_found) begin
                    dispatch_fire = 1'b1;
                    state_nxt     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (in_index_ack[ptr_q]) begin
                    ack_fire  = 1'b1;
                    state_nxt = DISPATCH;
                end
            end
            // Looking at this cycle's completions keeps done one edge after the last result.
            DRAIN: begin
                if (completed_nxt == total) state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            mu_q            <= '0;
            i_q             <= '0;
            j_q             <= '0;
            issued_q        <= '0;
            completed_q     <= '0;
            busy_q          <= '0;
            ptr_q           <= PTR_W'(NUM_PU - 1);
            out_index_ready <= '0;
            out_row_index   <= '0;
            out_col_index   <= '0;
            out_busy        <= 1'b0;
            out_done        <= 1'b0;
        end else begin
            out_busy    <= (state_nxt != IDLE);
            out_done    <= (state == DONE);
            completed_q <= start_fire ? '0 : completed_nxt;
            busy_q      <= (busy_q & ~accepted)
                         | (ack_fire ? (NUM_PU'(1) << ptr_q) : '0);
            if (start_fire) begin
                mu_q     <= in_mu;
                i_q      <= '0;
                j_q      <= '0;
                issued_q <= '0;
            end
            if (dispatch_fire) begin
                out_index_ready <= NUM_PU'(1) << pick_idx;
                out_row_index[pick_idx*INDEX_WIDTH +: INDEX_WIDTH] <= i_q;
                out_col_index[pick_idx*INDEX_WIDTH +: INDEX_WIDTH] <= j_q;
                ptr_q <= pick_idx;
            end
            if (ack_fire) begin
                out_index_ready <= '0;
                issued_q        <= issued_q + CNT_WIDTH'(1);
                if (j_q == mu_q - INDEX_WIDTH'(1)) begin
                    j_q <= '0;
                    i_q <= i_q + INDEX_WIDTH'(1);
                end else begin
                    j_q <= j_q + INDEX_WIDTH'(1);
                end
            end
        end
    end

`ifdef DISPATCH_PERF_COUNTER_EN
    logic [31:0] cycle_q;

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset)                          cycle_q <= '0;
        else if (start_fire)                   cycle_q <= '0;
        else if (out_busy && (cycle_q != '1))  cycle_q <= cycle_q + 32'd1;
    end

    assign out_cycle_count = cycle_q;
`else
    assign out_cycle_count = '0;
`endif

endmodule

// File: tb/tb_block_dispatcher.sv
// Randomized bench: emulates processors and checks against a transaction model.
module tb_block_dispatcher;

    localparam int NUM_PU = 2;
    localparam int IW     = 4;

    logic                 in_clk = 1'b0;
    logic                 in_reset;
    logic                 in_start;
    logic [IW-1:0]        in_mu;
    logic [NUM_PU-1:0]    in_index_ack;
    logic [NUM_PU-1:0]    in_result_ready;
    logic [NUM_PU-1:0]    out_index_ready;
    logic [NUM_PU*IW-1:0] out_row_index;
    logic [NUM_PU*IW-1:0] out_col_index;
    logic                 out_busy;
    logic                 out_done;
    logic [31:0]          out_cycle_count;

    block_dispatcher #(
        .NUM_PU      (NUM_PU),
        .INDEX_WIDTH (IW)
    ) dut (
        .in_clk          (in_clk),
        .in_reset        (in_reset),
        .in_start        (in_start),
        .in_mu           (in_mu),
        .in_index_ack    (in_index_ack),
        .in_result_ready (in_result_ready),
        .out_index_ready (out_index_ready),
        .out_row_index   (out_row_index),
        .out_col_index   (out_col_index),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_cycle_count (out_cycle_count)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pu_log[$];
    logic [NUM_PU-1:0] m_busy;
    int m_ptr;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_PU-1:0] busy, input int ptr);
        for (int k = 1; k <= NUM_PU; k++) begin
            if (!busy[(ptr + k) % NUM_PU]) return (ptr + k) % NUM_PU;
        end
        return -1;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, int'(out_index_ready), 0);
        check({tag, "_row"},   int'(out_row_index), 0);
        check({tag, "_col"},   int'(out_col_index), 0);
        check({tag, "_busy"},  int'(out_busy), 0);
        check({tag, "_done"},  int'(out_done), 0);
        check({tag, "_count"}, int'(out_cycle_count), 0);
    endtask

    // ack_k / rd0 / rd1 of 0 select random delays.
    task automatic run_job(input int mu, input int ack_k, input int rd0,
                           input int rd1, input bit noise,
                           input int abort_after);
        int cyc, total, issued, completed, s_cyc, done_due, limit, exp_p, idx;
        int rise_cyc[NUM_PU];
        int k_cur[NUM_PU];
        int res_edge[NUM_PU];
        logic [NUM_PU-1:0] prev_ready, ack_drv, res_drv, busy_b, acked;
        logic [NUM_PU*IW-1:0] prev_row, prev_col;
        bit start_drv, finished, eb;

        cyc = 0; total = mu * mu; issued = 0; completed = 0;
        s_cyc = -1; done_due = -1; limit = 6000; finished = 0;
        prev_ready = '0; ack_drv = '0; res_drv = '0;
        prev_row = '0; prev_col = '0;
        for (int p = 0; p < NUM_PU; p++) begin
            rise_cyc[p] = 0; k_cur[p] = 1; res_edge[p] = -1;
        end
        in_mu = IW'(mu);
        in_start = 1'b1;
        start_drv = 1'b1;
        in_index_ack = '0;
        in_result_ready = '0;

        while (!finished && cyc < limit) begin
            @(posedge in_clk);
            cyc++;
            @(negedge in_clk);
            busy_b = m_busy;
            acked = '0;
            if (start_drv && s_cyc < 0) begin
                s_cyc = cyc;
                if (total == 0) done_due = cyc + 1;
            end
            for (int p = 0; p < NUM_PU; p++) begin
                if (ack_drv[p] && prev_ready[p]) begin
                    acked[p] = 1'b1;
                    m_busy[p] = 1'b1;
                    issued++;
                    res_edge[p] = cyc + (p == 0 ? rd0 : rd1);
                    if ((p == 0 ? rd0 : rd1) == 0)
                        res_edge[p] = cyc + 3 + int'($urandom % 7);
                end
                if (res_drv[p] && busy_b[p]) begin
                    m_busy[p] = 1'b0;
                    completed++;
                end
            end
            if (s_cyc >= 0 && done_due < 0 && total > 0 && completed == total)
                done_due = cyc + 1;

            check("ready_onehot", int'($countones(out_index_ready) <= 1), 1);
            for (int p = 0; p < NUM_PU; p++) begin
                if (out_index_ready[p] && !prev_ready[p]) begin
                    exp_p = pick(busy_b, m_ptr);
                    check("dispatch_pu", p, exp_p);
                    check("dispatch_in_range", int'(issued < total), 1);
                    if (mu > 0) begin
                        check("dispatch_row", int'(out_row_index[p*IW +: IW]), issued / mu);
                        check("dispatch_col", int'(out_col_index[p*IW +: IW]), issued % mu);
                    end
                    idx = p * 256 + int'(out_row_index[p*IW +: IW]) * 16
                        + int'(out_col_index[p*IW +: IW]);
                    pu_log.push_back(idx);
                    m_ptr = p;
                    rise_cyc[p] = cyc;
                    k_cur[p] = (ack_k > 0) ? ack_k : 1 + int'($urandom % 4);
                end
                if (acked[p]) begin
                    check("ready_drop", int'(out_index_ready[p]), 0);
                end else if (prev_ready[p]) begin
                    check("ready_hold", int'(out_index_ready[p]), 1);
                    check("row_hold", int'(out_row_index[p*IW +: IW]),
                          int'(prev_row[p*IW +: IW]));
                    check("col_hold", int'(out_col_index[p*IW +: IW]),
                          int'(prev_col[p*IW +: IW]));
                end
            end
            eb = (s_cyc >= 0) && (done_due < 0 || cyc < done_due);
            check("done", int'(out_done), int'(cyc == done_due));
            check("busy", int'(out_busy), int'(eb));
            if (cyc == done_due) begin
`ifdef DISPATCH_PERF_COUNTER_EN
                check("cycle_count", int'(out_cycle_count), done_due - s_cyc);
`else
                check("cycle_count", int'(out_cycle_count), 0);
`endif
                finished = 1'b1;
            end
            prev_ready = out_index_ready;
            prev_row = out_row_index;
            prev_col = out_col_index;

            if (abort_after > 0 && issued >= abort_after) begin
                in_index_ack = '0;
                in_result_ready = '0;
                in_start = 1'b0;
                in_reset = 1'b1;
                #1;
                check_zero_outputs("abort");
                #2;
                in_reset = 1'b0;
                m_busy = '0;
                m_ptr = NUM_PU - 1;
                return;
            end

            for (int p = 0; p < NUM_PU; p++) begin
                ack_drv[p] = out_index_ready[p] && (cyc >= rise_cyc[p] + k_cur[p] - 1);
                if (!out_index_ready[p] && noise) ack_drv[p] = $urandom % 2 == 1;
                res_drv[p] = m_busy[p] && (res_edge[p] == cyc + 1);
                if (!m_busy[p] && noise) res_drv[p] = $urandom % 3 == 0;
            end
            start_drv = noise && eb && !finished && ($urandom % 4 == 0);
            in_start = start_drv;
            in_index_ack = ack_drv;
            in_result_ready = res_drv;
        end
        in_start = 1'b0;
        in_index_ack = '0;
        in_result_ready = '0;
        if (!finished) check("job_timeout", 0, 1);
    endtask

    initial begin
        in_reset = 1'b1;
        in_start = 1'b0;
        in_mu = '0;
        in_index_ack = '0;
        in_result_ready = '0;
        m_busy = '0;
        m_ptr = NUM_PU - 1;
        repeat (3) @(negedge in_clk);
        check_zero_outputs("reset");
        in_reset = 1'b0;
        @(negedge in_clk);

        pu_log.delete();
        run_job(2, 1, 5, 5, 1'b0, 0);
        check("seq_len", pu_log.size(), 4);
        if (pu_log.size() == 4) begin
            check("seq0", pu_log[0], 0);
            check("seq1", pu_log[1], 257);
            check("seq2", pu_log[2], 16);
            check("seq3", pu_log[3], 273);
        end

        pu_log.delete();
        run_job(0, 1, 5, 5, 1'b0, 0);
        check("mu0_no_dispatch", pu_log.size(), 0);

        run_job(2, 11, 4, 4, 1'b0, 0);
        run_job(2, 1, 8, 5, 1'b0, 0);

        run_job(3, 1, 5, 5, 1'b0, 2);
        pu_log.delete();
        run_job(1, 1, 4, 4, 1'b0, 0);
        check("post_reset_len", pu_log.size(), 1);
        if (pu_log.size() == 1) check("post_reset_pick", pu_log[0], 0);

        run_job(3, 0, 0, 0, 1'b1, 0);
        run_job(15, 0, 0, 0, 1'b0, 0);
        for (int n = 0; n < 6; n++) begin
            run_job(1 + int'($urandom % 5), 0, 0, 0, 1'($urandom % 2), 0);
        end
        run_job(0, 1, 3, 3, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
